tick_divider_prog: RTL and testbench

Programmable tick divider for the game timing chain. It counts single-cycle input ticks, such as a 100 ms timebase strobe, and emits a single-cycle output tick every DIV input ticks. It generalises the fixed-count timeout stage with a parametrised width, a runtime-loadable divisor, pause/stop/clear control and a one-shot mode with a done flag. It sits between the base timebase and the game-control FSM, and can be cascaded because the tick_out of one instance feeds the tick_in of the next.

---
 rtl/tick_divider_prog.sv | 130 +++++++++++++
 tb/tb_tick_divider_prog.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/tick_divider_prog.sv
// Programmable tick divider: emits one tick_out every div qualified tick_in strobes,
// with a runtime-loadable divisor, pause/stop/clear control and a one-shot mode.
module tick_divider_prog #(
   parameter int WIDTH       = 8,
   parameter int DEFAULT_DIV = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tick_in,
   input  logic             enable,
   input  logic             start,
   input  logic             stop,
   input  logic             clear,
   input  logic             oneshot,
   input  logic             div_load,
   input  logic [WIDTH-1:0] div_value,
   output logic             tick_out,
   output logic [WIDTH-1:0] count,
   output logic             running,
   output logic             done,
   output logic             load_err
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam logic [WIDTH-1:0] DIV_RST = WIDTH'(DEFAULT_DIV);
   localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

   state_t           state_reg, state_next;
   logic [WIDTH-1:0] count_reg, count_next;
   logic [WIDTH-1:0] div_reg, div_next;
   logic [WIDTH-1:0] pend_reg, pend_next;
   logic             pend_valid_reg, pend_valid_next;
   logic             mode_reg, mode_next;
   logic             tick_reg, tick_next;
   logic             err_reg, err_next;

   logic             qtick;
   logic             at_top;
   logic             load_ok;

   assign qtick   = tick_in & enable;
   assign at_top  = (count_reg == div_reg - ONE);
   assign load_ok = div_load && (div_value != '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg      <= IDLE;
         count_reg      <= '0;
         div_reg        <= DIV_RST;
         pend_reg       <= '0;
         pend_valid_reg <= 1'b0;
         mode_reg       <= 1'b0;
         tick_reg       <= 1'b0;
         err_reg        <= 1'b0;
      end else begin
         state_reg      <= state_next;
         count_reg      <= count_next;
         div_reg        <= div_next;
         pend_reg       <= pend_next;
         pend_valid_reg <= pend_valid_next;
         mode_reg       <= mode_next;
         tick_reg       <= tick_next;
         err_reg        <= err_next;
      end
   end

   always_comb begin
      state_next      = state_reg;
      count_next      = count_reg;
      div_next        = div_reg;
      pend_next       = pend_reg;
      pend_valid_next = pend_valid_reg;
      mode_next       = mode_reg;
      tick_next       = 1'b0;
      err_next        = div_load && (div_value == '0);

      if (clear) begin
         state_next      = IDLE;
         count_next      = '0;
         pend_valid_next = 1'b0;
      end else begin
         case (state_reg)
            RUN: begin
               // A load in RUN is parked so the current period finishes on the old divisor;
               // a load coinciding with a wrap or stop is therefore applied immediately.
               if (load_ok) begin
                  pend_next       = div_value;
                  pend_valid_next = 1'b1;
               end
               if (stop) begin
                  state_next      = IDLE;
                  pend_valid_next = 1'b0;
                  if (load_ok)             div_next = div_value;
                  else if (pend_valid_reg) div_next = pend_reg;
               end else if (start) begin
                  count_next = '0;
                  mode_next  = oneshot;
               end else if (qtick) begin
                  if (at_top) begin
                     count_next      = '0;
                     tick_next       = 1'b1;
                     pend_valid_next = 1'b0;
                     if (load_ok)             div_next = div_value;
                     else if (pend_valid_reg) div_next = pend_reg;
                     if (mode_reg) state_next = DONE;
                  end else begin
                     count_next = count_reg + ONE;
                  end
               end
            end
            default: begin
               if (load_ok) div_next = div_value;
               if (!stop && start) begin
                  state_next = RUN;
                  count_next = '0;
                  mode_next  = oneshot;
               end
            end
         endcase
      end
   end

   assign tick_out = tick_reg;
   assign count    = count_reg;
   assign running  = (state_reg == RUN);
   assign done     = (state_reg == DONE);
   assign load_err = err_reg;

endmodule

// File: tb/tb_tick_divider_prog.sv
// Self-checking bench for tick_divider_prog: a behavioural model predicts each cycle's
// outputs into a queue, and a monitor compares them against the DUT after every edge.
module tb_tick_divider_prog;

   localparam int WIDTH = 8;
   localparam int DEFAULT_DIV = 10;

   logic             clk = 1'b0;
   logic             rst;
   logic             tick_in, enable, start, stop, clear, oneshot, div_load;
   logic [WIDTH-1:0] div_value;
   logic             tick_out, running, done, load_err;
   logic [WIDTH-1:0] count;

   tick_divider_prog #(.WIDTH(WIDTH), .DEFAULT_DIV(DEFAULT_DIV)) dut (
      .clk(clk), .rst(rst), .tick_in(tick_in), .enable(enable), .start(start),
      .stop(stop), .clear(clear), .oneshot(oneshot), .div_load(div_load),
      .div_value(div_value), .tick_out(tick_out), .count(count), .running(running),
      .done(done), .load_err(load_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit t;
      int c;
      bit r;
      bit d;
      bit e;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;

   // Model: phase 0 = idle, 1 = counting, 2 = finished one-shot
   int   m_phase, m_count, m_div, m_pend;
   bit   m_oneshot;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s cycle=%0d: got %0d expected %0d", name, cyc, act, exp);
      end
   endtask

   task automatic model_reset();
      m_phase = 0; m_count = 0; m_div = DEFAULT_DIV; m_pend = -1; m_oneshot = 0;
   endtask

   function automatic exp_t model_step();
      exp_t e;
      bit   good_load = div_load && (div_value != 0);
      e.t = 0;
      e.e = div_load && (div_value == 0);
      if (clear) begin
         m_phase = 0; m_count = 0; m_pend = -1;
      end else if (m_phase != 1) begin
         if (good_load) m_div = int'(div_value);
         if (start && !stop) begin
            m_phase = 1; m_count = 0; m_oneshot = oneshot;
         end
      end else begin
         if (good_load) m_pend = int'(div_value);
         if (stop) begin
            m_phase = 0;
            if (m_pend >= 0) m_div = m_pend;
            m_pend = -1;
         end else if (start) begin
            m_count = 0; m_oneshot = oneshot;
         end else if (tick_in && enable) begin
            m_count = m_count + 1;
            if (m_count == m_div) begin
               m_count = 0; e.t = 1;
               if (m_pend >= 0) m_div = m_pend;
               m_pend = -1;
               if (m_oneshot) m_phase = 2;
            end
         end
      end
      e.c = m_count;
      e.r = (m_phase == 1);
      e.d = (m_phase == 2);
      return e;
   endfunction

   task automatic step();
      q.push_back(model_step());
      @(posedge clk);
      @(negedge clk);
      cyc++;
      tick_in = 0; start = 0; stop = 0; clear = 0; div_load = 0;
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   // tick every `gap` cycles, `n` ticks total
   task automatic ticks(input int n, input int gap);
      for (int i = 0; i < n; i++) begin
         tick_in = 1;
         step();
         for (int j = 1; j < gap; j++) step();
      end
   endtask

   task automatic load(input int v);
      div_load = 1; div_value = WIDTH'(v);
      step();
   endtask

   task automatic do_start(input bit os);
      start = 1; oneshot = os;
      step();
   endtask

   task automatic check_zero_outputs(input string tag);
      chk({tag, "_tick_out"}, int'(tick_out), 0);
      chk({tag, "_count"},    int'(count),    0);
      chk({tag, "_running"},  int'(running),  0);
      chk({tag, "_done"},     int'(done),     0);
      chk({tag, "_load_err"}, int'(load_err), 0);
   endtask

   // Monitor: one expected record per clock edge, compared 1 time unit after the edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() != 0) begin
            e = q.pop_front();
            chk("tick_out", int'(tick_out), int'(e.t));
            chk("count",    int'(count),    e.c);
            chk("running",  int'(running),  int'(e.r));
            chk("done",     int'(done),     int'(e.d));
            chk("load_err", int'(load_err), int'(e.e));
            if (tick_out) $display("tick_out cycle=%0d count=%0d running=%0d done=%0d",
                                   cyc, count, running, done);
         end
      end
   end

   initial begin
      rst = 1; tick_in = 0; enable = 1; start = 0; stop = 0; clear = 0;
      oneshot = 0; div_load = 0; div_value = '0;
      model_reset();
      @(negedge clk); @(negedge clk);
      check_zero_outputs("reset");
      rst = 0;
      idle_cycles(2);

      // Periodic, default divisor 10, a tick every 4th cycle
      ticks(3, 1);                       // ignored while idle
      do_start(0);
      ticks(31, 4);
      stop = 1; step();

      // One-shot with div=3, then restart periodic
      load(3);
      do_start(1);
      ticks(6, 2);
      do_start(0);
      ticks(4, 1);

      // Load during a run: old period completes, then new divisor
      clear = 1; step();
      load(5);
      do_start(0);
      ticks(2, 2);
      load(2);
      ticks(12, 2);
      load(0);                            // rejected
      ticks(5, 1);

      // Pause, then stop coinciding with a wrap
      enable = 0;
      ticks(20, 2);
      enable = 1;
      for (int i = 0; i < 300 && m_count != m_div - 1; i++) begin
         tick_in = 1; step();
      end
      tick_in = 1; stop = 1; step();
      idle_cycles(2);
      do_start(0);
      ticks(1, 1);
      clear = 1; start = 1; step();
      idle_cycles(2);

      // div=1 with continuous tick_in
      load(1);
      do_start(0);
      for (int i = 0; i < 10; i++) begin tick_in = 1; step(); end
      idle_cycles(2);

      // Asynchronous reset mid-run, then default divisor again
      load(7);
      do_start(0);
      ticks(4, 1);
      rst = 1;
      #1;
      check_zero_outputs("async_rst");
      model_reset();
      @(posedge clk);
      @(negedge clk);
      rst = 0;
      do_start(0);
      ticks(12, 1);

      // Randomised traffic
      for (int i = 0; i < 2000; i++) begin
         tick_in   = ($urandom_range(0, 1) == 1);
         enable    = ($urandom_range(0, 7) != 0);
         start     = ($urandom_range(0, 39) == 0);
         stop      = ($urandom_range(0, 59) == 0);
         clear     = ($urandom_range(0, 99) == 0);
         oneshot   = ($urandom_range(0, 2) == 0);
         div_load  = ($urandom_range(0, 29) == 0);
         div_value = WIDTH'($urandom_range(0, 5));
         step();
      end

      @(posedge clk); #2;
      chk("queue_drained", q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
